// File: rtl/run_detector_if.sv
// Purpose: groups the sample/control inputs and detection outputs of
//          run_detector into one bundle.
// Signals:
//   En       sample enable (0 holds all state)
//   w        serial data sample
//   Mode     bit0 enables 0-run detection, bit1 enables 1-run detection
//   Retrig   0 = sustain, 1 = retrigger every RUN_LEN samples
//   z0/z1/z  0-run, 1-run and combined detection flags
//   RunLen   current run length
//   State    IDLE=00, RUN0=01, RUN1=10
//   HitCount saturating count of detection events
// Modports: master drives the inputs (board side), slave is the detector.
interface run_detector_if #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned HIT_W = 8
);
  logic             En;
  logic             w;
  logic [1:0]       Mode;
  logic             Retrig;
  logic             z0;
  logic             z1;
  logic             z;
  logic [CNT_W-1:0] RunLen;
  logic [1:0]       State;
  logic [HIT_W-1:0] HitCount;

  modport master (
    output En, w, Mode, Retrig,
    input  z0, z1, z, RunLen, State, HitCount
  );

  modport slave (
    input  En, w, Mode, Retrig,
    output z0, z1, z, RunLen, State, HitCount
  );
endinterface

// File: rtl/run_detector.sv
// Purpose: detects RUN_LEN consecutive equal samples of serial input w,
//          with independently enabled 0/1 runs, sustain or retrigger
//          behaviour and a saturating detection-event counter.
// Ports:
//   Clock  rising-edge clock for all state
//   Reset  synchronous active-high reset (priority over En)
//   bus    run_detector_if.slave: En, w, Mode, Retrig in;
//          z0, z1, z, RunLen, State, HitCount out
// z0/z1/z are a Moore decode of the registered state combined with the
// live Mode bits, so Mode changes show up without a clock edge.
module run_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned HIT_W   = 8
) (
  input logic           Clock,
  input logic           Reset,
  run_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN0 = 2'b01,
    RUN1 = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] run_nxt;
  logic [HIT_W-1:0] hits;
  logic             hit_inc;

  // Same-bit continuation: count up to RUN_LEN, then hold or wrap to 1.
  function automatic logic [CNT_W-1:0] extend(input logic [CNT_W-1:0] r,
                                              input logic             wrap);
    if (r >= RUN_MAX) return wrap ? RUN_ONE : RUN_MAX;
    return r + RUN_ONE;
  endfunction

  // Next state / run length for one enabled sample.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    case (state)
      IDLE: begin
        state_nxt = bus.w ? RUN1 : RUN0;
        run_nxt   = RUN_ONE;
      end
      RUN0: begin
        if (bus.w) begin
          state_nxt = RUN1;
          run_nxt   = RUN_ONE;
        end else begin
          run_nxt = extend(run, bus.Retrig);
        end
      end
      RUN1: begin
        if (!bus.w) begin
          state_nxt = RUN0;
          run_nxt   = RUN_ONE;
        end else begin
          run_nxt = extend(run, bus.Retrig);
        end
      end
      default: begin
        state_nxt = IDLE;
        run_nxt   = '0;
      end
    endcase
  end

  // A detection event is the edge on which the run first reaches RUN_LEN
  // for a polarity that Mode currently enables.
  assign hit_inc = (run_nxt == RUN_MAX) && (run != RUN_MAX) &&
                   (((state_nxt == RUN0) && bus.Mode[0]) ||
                    ((state_nxt == RUN1) && bus.Mode[1]));

  // State, run length and saturating event counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      run   <= '0;
      hits  <= '0;
    end else if (bus.En) begin
      state <= state_nxt;
      run   <= run_nxt;
      if (hit_inc && !(&hits)) hits <= hits + HIT_W'(1);
    end
  end

  assign bus.z0       = (state == RUN0) && (run == RUN_MAX) && bus.Mode[0];
  assign bus.z1       = (state == RUN1) && (run == RUN_MAX) && bus.Mode[1];
  assign bus.z        = bus.z0 | bus.z1;
  assign bus.RunLen   = run;
  assign bus.State    = state;
  assign bus.HitCount = hits;

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised successor to the lab's fixed 4-in-a-row sequence detector.
- Detects RUN_LEN consecutive equal samples of serial input w.
- Runs of 0s and 1s can be enabled independently.
- Selectable sustain or retrigger detection.
- Keeps a saturating count of detection events.
- Sits between board switches/keys and LEDs: clock from a push-button, outputs on LEDR/LEDG.

Parameters:
- RUN_LEN, 4, number of consecutive equal samples that constitutes a detection; legal range 2..2^CNT_W-1.
- CNT_W, 3, width of the run-length counter; must satisfy 2^CNT_W > RUN_LEN.
- HIT_W, 8, width of the detection-event counter.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  sample enable; 0 holds all registered state.
- w  input  1  serial data sample.
- Mode  input  2  bit0 enables 0-run detection; bit1 enables 1-run detection.
- Retrig  input  1  0 = sustain, 1 = retrigger (one pulse per RUN_LEN samples).
- z0  output  1  0-run detected.
- z1  output  1  1-run detected.
- z  output  1  z0 OR z1.
- RunLen  output  CNT_W  current run length (registered counter).
- State  output  2  FSM state: IDLE=00, RUN0=01, RUN1=10.
- HitCount  output  HIT_W  number of detection events since reset, saturating.

Behaviour:
- Reset:
  - Applied on the Clock edge when Reset=1; has priority over En.
  - Sets State=IDLE, RunLen=0, HitCount=0.
  - z0/z1/z decode to 0 in the same cycle.
  - Reset mid-run discards the run completely.
- En=0 (Reset=0): State, RunLen and HitCount hold; w is ignored.
- With En=1, each edge samples w and updates (state, run) as follows.
  - IDLE:
    - w=0 -> RUN0, run=1.
    - w=1 -> RUN1, run=1.
  - RUN0:
    - w=1 -> RUN1, run=1.
    - w=0, run<RUN_LEN -> RUN0, run+1.
    - w=0, run==RUN_LEN, Retrig=0 -> RUN0, run=RUN_LEN (saturate).
    - w=0, run==RUN_LEN, Retrig=1 -> RUN0, run=1 (wrap).
  - RUN1: mirror of RUN0 with w inverted.
  - Encoding 11 is illegal: next state is IDLE with run=0.
- Outputs (Moore decode of registered state plus live Mode, no extra register):
  - z0 = (State==RUN0) AND (RunLen==RUN_LEN) AND Mode[0].
  - z1 = (State==RUN1) AND (RunLen==RUN_LEN) AND Mode[1].
  - z = z0 OR z1.
- Latency: z rises in the cycle immediately after the edge that samples the RUN_LEN-th consecutive equal bit.
- Sustain mode: z stays high while the run continues and drops on the edge that samples the opposite bit.
- Retrigger mode: z is high for exactly one cycle per RUN_LEN equal samples.
- HitCount:
  - Increments on an enabled edge where next run==RUN_LEN AND current run!=RUN_LEN AND the polarity of the next state is enabled by Mode at that edge.
  - Holds at all-ones (saturates, no wrap).
- Mode changes:
  - Affect z0/z1 immediately.
  - Never alter State or RunLen.
  - Runs are tracked even when their polarity is disabled.
- Retrig changes:
  - Take effect at the next edge where run==RUN_LEN.
  - Switching to 1 while saturated wraps run to 1 on the next same-bit sample.
  - Switching to 0 resumes normal counting.

Test Plan:
All cases use RUN_LEN=4, Mode=11, Retrig=0, En=1 unless stated.
- Reset, then w=0 for 4 edges -> after edge 4: State=01, RunLen=4, z0=1, z=1, HitCount=1. Then 3 more 0s -> z0 stays 1, HitCount stays 1. Then w=1 -> z0=0, State=10, RunLen=1.
- Retrig=1, w=1 for 8 edges -> z1 high only in the cycles after edges 4 and 8; RunLen sequence 1,2,3,4,1,2,3,4; HitCount=2.
- w sequence 0,0,0,1,1,1,1 -> z0 never asserts; z1=1 after edge 7; HitCount=1.
- Run of 3 ones, En=0 for 5 edges with w=0, then En=1 with one more w=1 -> RunLen holds at 3 while En=0, then reads 4; z1=1; HitCount=1.
- Mode=01, w=1 for 4 edges -> State=10, RunLen=4, z1=0, z=0, HitCount=0. Then set Mode=11 with no clock -> z1=1 immediately, HitCount stays 0.
- Reset=1 asserted mid-run, including a case with En=0 in the same cycle -> after the edge: State=00, RunLen=0, z=0, HitCount=0. HitCount saturation: with HIT_W=2, 5 detection events -> HitCount=3.
